// File: rtl/fifo_sync_pkg.sv
// Shared constants and helpers for the fifo_sync_flex FIFO.
//   DEF_DATA_W / DEF_DEPTH : default payload width and entry count
//   cnt_width()            : occupancy counter width, able to hold 0..DEPTH
package fifo_sync_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_DEPTH  = 16;

  // One extra bit over the pointer width so that count can reach DEPTH.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
//   i_clock, i_reset_n : clock, async active-low reset (read register only)
//   i_wr_en/addr/data  : synchronous write
//   i_rd_en/addr       : read request; o_rd_data updates one edge later
//   o_rd_data          : registered read data, holds when no read
module fifo_sync_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Storage array is intentionally not reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read register clears on reset and holds between reads.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)   r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_flex.sv
// Synchronous single-clock FIFO with registered read data and status flags.
//   clock, reset_n          : clock, async active-low reset
//   w_enable, write_data    : write request and payload
//   r_enable                : read request
//   read_data, read_valid   : registered payload, one-cycle valid pulse
//   full, empty             : occupancy == DEPTH / == 0
//   almost_full/empty       : count >= AF_LEVEL / count <= AE_LEVEL
//   count                   : occupancy 0..DEPTH
//   overflow, underflow     : sticky error flags, present only when
//                             FIFO_SYNC_FLEX_ERR_EN is defined, else tied 0
module fifo_sync_flex
  import fifo_sync_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        w_enable,
  input  logic                        r_enable,
  input  logic [DATA_W-1:0]           write_data,
  output logic [DATA_W-1:0]           read_data,
  output logic                        read_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  // Reject illegal configurations at elaboration.
  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
    $error("fifo_sync_flex: DEPTH must be a power of two in 4..1024");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("fifo_sync_flex: AE_LEVEL must be below AF_LEVEL");
  end
  if (DATA_W < 1 || DATA_W > 64) begin : g_bad_width
    $error("fifo_sync_flex: DATA_W must be 1..64");
  end

  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_read_valid;
  logic             w_wr_acc;
  logic             w_rd_acc;

  // No bypass: a read needs stored data; a write into a full FIFO needs a paired read.
  assign w_rd_acc = r_enable && !empty;
  assign w_wr_acc = w_enable && (!full || w_rd_acc);

  // Pointers wrap naturally at the power-of-two boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_read_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + PTR_W'(1);
      if (w_rd_acc) r_rptr <= r_rptr + PTR_W'(1);
      r_read_valid <= w_rd_acc;
    end
  end

  // Occupancy counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  fifo_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wptr),
    .i_wr_data (write_data),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (r_rptr),
    .o_rd_data (read_data)
  );

  assign read_valid   = r_read_valid;
  assign count        = r_count;
  assign full         = (r_count == CNT_W'(DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));

`ifdef FIFO_SYNC_FLEX_ERR_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky until reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_enable && !w_wr_acc) r_overflow  <= 1'b1;
      if (r_enable && empty)     r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Self-checking bench for fifo_sync_flex (DATA_W=8, DEPTH=16, AF=14, AE=2).
// A queue-based model predicts every output; a negedge process compares
// against it each cycle, and directed sequences add literal expectations.
module tb_fifo_sync_flex;

  localparam int DEPTH = 16;
`ifdef FIFO_SYNC_FLEX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       w_enable, r_enable;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       read_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  fifo_sync_flex dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .w_enable     (w_enable),
    .r_enable     (r_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored bytes.
  logic [7:0] q[$];
  logic [7:0] m_rdata = 8'h00;
  bit         m_rvalid = 1'b0;
  bit         m_ovf = 1'b0, m_unf = 1'b0;
  bit         m_wa, m_ra;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_rdata  = 8'h00;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else begin
      m_ra = r_enable && (q.size() > 0);
      m_wa = w_enable && ((q.size() < DEPTH) || m_ra);
      if (ERR_EN && w_enable && !m_wa) m_ovf = 1'b1;
      if (ERR_EN && r_enable && q.size() == 0) m_unf = 1'b1;
      m_rvalid = m_ra;
      if (m_ra) m_rdata = q.pop_front();
      if (m_wa) q.push_back(write_data);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("count",        64'(count),        64'(q.size()));
      chk("full",         64'(full),         64'(q.size() == DEPTH));
      chk("empty",        64'(empty),        64'(q.size() == 0));
      chk("almost_full",  64'(almost_full),  64'(q.size() >= DEPTH - 2));
      chk("almost_empty", 64'(almost_empty), 64'(q.size() <= 2));
      chk("read_valid",   64'(read_valid),   64'(m_rvalid));
      chk("read_data",    64'(read_data),    64'(m_rdata));
      chk("overflow",     64'(overflow),     64'(m_ovf));
      chk("underflow",    64'(underflow),    64'(m_unf));
    end
  end

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    w_enable   = w;
    r_enable   = r;
    write_data = d;
    @(posedge clock);
    #1;
    w_enable = 1'b0;
    r_enable = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int bias;
    reset_n    = 1'b0;
    w_enable   = 1'b0;
    r_enable   = 1'b0;
    write_data = 8'h00;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clock); #1;

    // Reset state.
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ae",    64'(almost_empty), 64'd1);
    chk("rst_full",  64'(full), 64'd0);
    chk("rst_af",    64'(almost_full), 64'd0);
    chk("rst_rv",    64'(read_valid), 64'd0);

    // Fill 0x00..0x0F, read back in order.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_full",  64'(full),  64'd1);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("seq_rd", 64'(read_data), 64'(i));
      chk("seq_rv", 64'(read_valid), 64'd1);
    end
    chk("seq_empty", 64'(empty), 64'd1);

    // Overflow attempt at full.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b0, 8'hAA);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag",  64'(overflow), 64'(ERR_EN));

    // Simultaneous write+read at full.
    cyc(1'b1, 1'b1, 8'h55);
    chk("fullrw_count", 64'(count), 64'd16);
    chk("fullrw_data",  64'(read_data), 64'h20);
    chk("fullrw_full",  64'(full), 64'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("fullrw_last", 64'(read_data), 64'h55);

    // Simultaneous write+read at empty: no bypass.
    cyc(1'b1, 1'b1, 8'h11);
    chk("emprw_rv",    64'(read_valid), 64'd0);
    chk("emprw_count", 64'(count), 64'd1);
    cyc(1'b0, 1'b1, 8'h00);
    chk("emprw_data",  64'(read_data), 64'h11);
    cyc(1'b0, 1'b1, 8'h00);
    chk("unf_flag",    64'(underflow), 64'(ERR_EN));
    chk("unf_rv",      64'(read_valid), 64'd0);
    chk("unf_hold",    64'(read_data), 64'h11);

    // Threshold ramp.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 1'b0, 8'(k));
      chk("ramp_af", 64'(almost_full),  64'(k >= 14));
      chk("ramp_ae", 64'(almost_empty), 64'(k <= 2));
    end
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);

    // 40 interleaved write/read pairs: pointers wrap more than twice.
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      cyc(1'b1, 1'b0, d);
      cyc(1'b0, 1'b1, 8'h00);
      chk("inter_rd", 64'(read_data), 64'(d));
    end

    // Randomized traffic with shifting write bias.
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) bias = (i / 100) % 3 == 0 ? 30 : ((i / 100) % 3 == 1 ? 50 : 80);
      cyc(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) < 50), 8'($urandom));
    end

    // Drain, bounded.
    for (int i = 0; i < 40 && count != 0; i++) cyc(1'b0, 1'b1, 8'h00);
    chk("drain_count", 64'(count), 64'd0);

    // Asynchronous reset mid-stream at count 9.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'h90 + i));
    chk("pre_rst_count", 64'(count), 64'd9);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b0, 8'h99);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_rv",    64'(read_valid), 64'd0);
    chk("arst_rd",    64'(read_data), 64'd0);
    chk("arst_ovf",   64'(overflow), 64'd0);
    chk("arst_unf",   64'(underflow), 64'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    cyc(1'b1, 1'b0, 8'h3C);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_rst_rd", 64'(read_data), 64'h3C);
    chk("post_rst_rv", 64'(read_valid), 64'd1);
    cyc(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
